lock_seq_ctrl: RTL and testbench

Sequencing controller for the digital lock's passcode path. Collects keypad digits into an entry buffer, compares against a stored code on `enter`, and grants or denies access. Counts consecutive failures and enforces a timed lockout. Lets an unlocked user reprogram the code. Sits between the keypad debouncer/encoder and the LED/actuator drivers, replacing the single-flag default-password check.

---
 rtl/lock_pkg.sv | 19 +
 rtl/lock_seq_ctrl_if.sv | 24 ++
 rtl/lockout_timer.sv | 46 ++++
 rtl/lock_seq_ctrl.sv | 117 +++++++++++
 tb/tb_lock_seq_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding, LED patterns and digit width for the passcode controller
package lock_pkg;
  localparam int DIGIT_W = 4;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    PROG    = 3'd4,
    LOCKOUT = 3'd5
  } lock_state_t;
  localparam logic [2:0] LED_LOCKED  = 3'b000;
  localparam logic [2:0] LED_OPEN    = 3'b110;
  localparam logic [2:0] LED_PROG    = 3'b101;
  localparam logic [2:0] LED_LOCKOUT = 3'b001;
  function automatic logic [2:0] led_of(lock_state_t s);
    return s == OPEN ? LED_OPEN : s == PROG ? LED_PROG : s == LOCKOUT ? LED_LOCKOUT : LED_LOCKED;
  endfunction
endpackage

// File: rtl/lock_seq_ctrl_if.sv
// lock_seq_ctrl_if: keypad strobes in, lock status out
interface lock_seq_ctrl_if;
  logic                         digit_valid;
  logic [lock_pkg::DIGIT_W-1:0] digit;
  logic                         enter;
  logic                         clear;
  logic                         prog;
  logic                         relock;
  logic                         unlocked;
  logic                         fail_pulse;
  logic                         lockout;
  logic                         alarm;
  logic [2:0]                   tries_left;
  logic [3:0]                   digit_cnt;
  logic [2:0]                   led;
  modport master (
    output digit_valid, digit, enter, clear, prog, relock,
    input  unlocked, fail_pulse, lockout, alarm, tries_left, digit_cnt, led
  );
  modport slave (
    input  digit_valid, digit, enter, clear, prog, relock,
    output unlocked, fail_pulse, lockout, alarm, tries_left, digit_cnt, led
  );
endinterface

// File: rtl/lockout_timer.sv
// lockout_timer: counts the lockout window; LOCK_SEQ_ALARM_EN adds a 64-cycle alarm toggle
module lockout_timer #(
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic alarm
);
  localparam int CW = $clog2(LOCKOUT_CYCLES);
  logic [CW-1:0] cnt;
  assign done = busy && cnt == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(LOCKOUT_CYCLES - 1);
    end else if (busy) begin
      busy <= !done;
      cnt  <= done ? cnt : cnt - CW'(1);
    end
  end
`ifdef LOCK_SEQ_ALARM_EN
  logic [5:0] ph;
  logic       tog;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph  <= '0;
      tog <= 1'b0;
    end else if (start) begin
      ph  <= '0;
      tog <= 1'b1;
    end else if (busy) begin
      ph  <= ph + 6'd1;
      tog <= ph == 6'd63 ? ~tog : tog;
    end
  end
  assign alarm = busy & tog;
`else
  assign alarm = 1'b0;
`endif
endmodule

// File: rtl/lock_seq_ctrl.sv
// lock_seq_ctrl: passcode entry/check/reprogram FSM with retry lockout; LOCK_SEQ_ALARM_EN enables the lockout alarm
module lock_seq_ctrl
  import lock_pkg::*;
#(
  parameter int                           CODE_LEN       = 4,
  parameter int                           MAX_TRIES      = 3,
  parameter int                           LOCKOUT_CYCLES = 1000,
  parameter logic [DIGIT_W*CODE_LEN-1:0]  DEFAULT_CODE   = 16'h1234
) (
  input  logic             clk,
  input  logic             rst,
  lock_seq_ctrl_if.slave   bus
);
  localparam int         W    = DIGIT_W * CODE_LEN;
  localparam logic [3:0] LEN  = 4'(CODE_LEN);
  localparam logic [2:0] MAXT = 3'(MAX_TRIES);
  lock_state_t state, state_n;
  logic [W-1:0] entry, entry_n, code, code_n;
  logic [3:0]   cnt, cnt_n;
  logic [2:0]   fails, fails_n;
  logic         fail_q, fail_n;
  logic         rl, cl, en, pg, dv, take, match, last_try, start, t_busy, t_done;
  // one strobe wins per cycle: relock > clear > enter > prog > digit
  assign rl       = bus.relock;
  assign cl       = bus.clear & ~rl;
  assign en       = bus.enter & ~rl & ~bus.clear;
  assign pg       = bus.prog & ~(rl | bus.clear | bus.enter);
  assign dv       = bus.digit_valid & ~(rl | bus.clear | bus.enter | bus.prog) & (bus.digit <= 4'd9);
  assign take     = dv & (state == IDLE || state == ENTRY || state == PROG) & (cnt < LEN);
  assign match    = cnt == LEN && entry == code;
  assign last_try = fails == MAXT - 3'd1;
  assign start    = state == CHECK && !match && last_try;
  always_comb begin
    state_n = state;
    entry_n = entry;
    cnt_n   = cnt;
    fails_n = fails;
    code_n  = code;
    fail_n  = 1'b0;
    if (take) begin
      entry_n = {entry[W-DIGIT_W-1:0], bus.digit};
      cnt_n   = cnt + 4'd1;
      state_n = state == IDLE ? ENTRY : state;
    end
    case (state)
      IDLE: ;
      ENTRY: begin
        if (cl) begin
          state_n = IDLE;
          entry_n = '0;
          cnt_n   = '0;
        end else if (en) state_n = CHECK;
      end
      CHECK: begin
        entry_n = '0;
        cnt_n   = '0;
        fail_n  = !match;
        fails_n = match ? 3'd0 : fails + 3'd1;
        state_n = match ? OPEN : last_try ? LOCKOUT : IDLE;
      end
      OPEN: begin
        if (rl) state_n = IDLE;
        else if (pg) begin
          state_n = PROG;
          entry_n = '0;
          cnt_n   = '0;
        end
      end
      PROG: begin
        if (rl | cl | en) begin
          state_n = rl ? IDLE : OPEN;
          entry_n = '0;
          cnt_n   = '0;
          code_n  = en && cnt == LEN ? entry : code;
        end
      end
      LOCKOUT: begin
        if (t_done) begin
          state_n = IDLE;
          fails_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      entry  <= '0;
      cnt    <= '0;
      fails  <= '0;
      code   <= DEFAULT_CODE;
      fail_q <= 1'b0;
    end else begin
      state  <= state_n;
      entry  <= entry_n;
      cnt    <= cnt_n;
      fails  <= fails_n;
      code   <= code_n;
      fail_q <= fail_n;
    end
  end
  lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (t_busy),
    .done  (t_done),
    .alarm (bus.alarm)
  );
  assign bus.unlocked   = state == OPEN || state == PROG;
  assign bus.fail_pulse = fail_q;
  assign bus.lockout    = t_busy;
  assign bus.tries_left = MAXT - fails;
  assign bus.digit_cnt  = cnt;
  assign bus.led        = led_of(state);
endmodule

// File: tb/tb_lock_seq_ctrl.sv
// tb_lock_seq_ctrl: directed scoreboard bench for lock_seq_ctrl (LOCK_SEQ_ALARM_EN selects alarm expectations)
module tb_lock_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  lock_seq_ctrl_if bus();
  lock_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
  localparam logic [4:0] S_DV = 5'b00001, S_PG = 5'b00010, S_EN = 5'b00100, S_CL = 5'b01000, S_RL = 5'b10000;
  typedef struct {logic ok; int fails;} res_t;
  res_t        sb[$];
  int          n_chk = 0, n_fail = 0;
  logic [15:0] exp_code = 16'h1234;
  int          exp_fails = 0;
  logic [15:0] mbuf = '0;
  int          mlen = 0;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic strobe(input logic [4:0] s, input logic [3:0] d);
    {bus.relock, bus.clear, bus.enter, bus.prog, bus.digit_valid} = s;
    bus.digit = d;
    @(negedge clk);
    {bus.relock, bus.clear, bus.enter, bus.prog, bus.digit_valid} = '0;
    bus.digit = '0;
  endtask
  task automatic key(input logic [3:0] d);
    strobe(S_DV, d);
    if (d <= 4'd9 && mlen < 4) begin
      mbuf = {mbuf[11:0], d};
      mlen++;
    end
  endtask
  task automatic keys(input int n, input logic [31:0] ds);
    for (int i = n - 1; i >= 0; i--) key(ds[4*i +: 4]);
  endtask
  task automatic model_clear();
    mbuf = '0;
    mlen = 0;
  endtask
  task automatic attempt(input string tag);
    res_t r, e;
    r.ok    = mlen == 4 && mbuf == exp_code;
    r.fails = r.ok ? 0 : exp_fails + 1;
    sb.push_back(r);
    chk({tag, " digit_cnt"}, bus.digit_cnt, 16'(mlen));
    strobe(S_EN, 4'd0);
    model_clear();
    chk({tag, " in_check"}, {15'd0, bus.unlocked}, 16'd0);
    @(negedge clk);
    e = sb.pop_front();
    exp_fails = e.fails;
    chk({tag, " unlocked"}, {15'd0, bus.unlocked}, {15'd0, e.ok});
    chk({tag, " fail_pulse"}, {15'd0, bus.fail_pulse}, {15'd0, !e.ok});
    chk({tag, " tries_left"}, {13'd0, bus.tries_left}, 16'(3 - e.fails));
    chk({tag, " lockout"}, {15'd0, bus.lockout}, {15'd0, e.fails == 3});
    chk({tag, " led"}, {13'd0, bus.led}, e.ok ? 16'h6 : e.fails == 3 ? 16'h1 : 16'h0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " unlocked"}, {15'd0, bus.unlocked}, 16'd0);
    chk({tag, " fail_pulse"}, {15'd0, bus.fail_pulse}, 16'd0);
    chk({tag, " lockout"}, {15'd0, bus.lockout}, 16'd0);
    chk({tag, " alarm"}, {15'd0, bus.alarm}, 16'd0);
    chk({tag, " tries_left"}, {13'd0, bus.tries_left}, 16'd3);
    chk({tag, " digit_cnt"}, {12'd0, bus.digit_cnt}, 16'd0);
    chk({tag, " led"}, {13'd0, bus.led}, 16'd0);
  endtask
  function automatic logic exp_alarm(input int k);
`ifdef LOCK_SEQ_ALARM_EN
    return ((k / 64) % 2) == 0;
`else
    return 1'b0 & (k == 0);
`endif
  endfunction
  initial begin
    int lk, alarm_bad;
    rst = 1'b1;
    {bus.relock, bus.clear, bus.enter, bus.prog, bus.digit_valid} = '0;
    bus.digit = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("reset");
    keys(4, 32'h1234);
    attempt("good1234");
    strobe(S_RL, 4'd0);
    chk("relock led", {13'd0, bus.led}, 16'd0);
    keys(4, 32'h1235);
    attempt("bad1235");
    @(negedge clk);
    chk("pulse width", {15'd0, bus.fail_pulse}, 16'd0);
    keys(3, 32'h123);
    attempt("short123");
    keys(4, 32'h0000);
    attempt("third_fail");
    lk = 0;
    alarm_bad = 0;
    for (int i = 0; i < 1100; i++) begin
      if (bus.lockout) begin
        if (bus.alarm !== exp_alarm(lk)) alarm_bad++;
        lk++;
      end else if (bus.alarm !== 1'b0) alarm_bad++;
      if (i >= 5 && i <= 8) strobe(S_DV, 4'(i - 4));
      else if (i == 9) strobe(S_EN, 4'd0);
      else @(negedge clk);
    end
    exp_fails = 0;
    chk("lockout length", 16'(lk), 16'd1000);
    chk("alarm pattern", 16'(alarm_bad), 16'd0);
    chk("post lockout tries", {13'd0, bus.tries_left}, 16'd3);
    chk("lockout ignores code", {15'd0, bus.unlocked}, 16'd0);
    chk("lockout ignores digits", {12'd0, bus.digit_cnt}, 16'd0);
    keys(4, 32'h1234);
    attempt("after_lockout");
    strobe(S_RL, 4'd0);
    keys(6, 32'h12A345);
    attempt("overflow");
    strobe(S_RL, 4'd0);
    keys(2, 32'h12);
    strobe(S_CL | S_EN, 4'd0);
    model_clear();
    chk("clr_en digit_cnt", {12'd0, bus.digit_cnt}, 16'd0);
    @(negedge clk);
    chk("clr_en no pulse", {15'd0, bus.fail_pulse}, 16'd0);
    chk("clr_en tries", {13'd0, bus.tries_left}, 16'd3);
    keys(4, 32'h1234);
    attempt("pre_prog");
    strobe(S_PG, 4'd0);
    chk("prog led", {13'd0, bus.led}, 16'h5);
    keys(4, 32'h9876);
    strobe(S_EN, 4'd0);
    model_clear();
    exp_code = 16'h9876;
    chk("prog done led", {13'd0, bus.led}, 16'h6);
    strobe(S_RL, 4'd0);
    keys(4, 32'h1234);
    attempt("old_code");
    keys(4, 32'h9876);
    attempt("new_code");
    strobe(S_PG, 4'd0);
    keys(3, 32'h555);
    strobe(S_EN, 4'd0);
    model_clear();
    chk("short prog led", {13'd0, bus.led}, 16'h6);
    strobe(S_RL, 4'd0);
    keys(4, 32'h9876);
    attempt("code_kept");
    strobe(S_RL, 4'd0);
    for (int i = 0; i < 3; i++) begin
      keys(1, 32'h1);
      attempt("pre_rst_fail");
    end
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("rst_lockout");
    @(negedge clk);
    rst = 1'b0;
    exp_code = 16'h1234;
    exp_fails = 0;
    model_clear();
    @(negedge clk);
    keys(4, 32'h1234);
    attempt("code_restored");
    strobe(S_PG, 4'd0);
    keys(2, 32'h99);
    #2 rst = 1'b1;
    #1 chk_reset("rst_prog");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    keys(4, 32'h1234);
    attempt("after_rst_prog");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
